// File: rtl/prescaled_timer_pkg.sv
// prescaled_timer shared types: counting modes and control states.
package prescaled_timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The reserved encoding behaves exactly like free-run.
  function automatic mode_e norm_mode(input logic [1:0] m);
    mode_e r;
    r = mode_e'(m);
    if (r == MODE_RSVD) r = MODE_FREE;
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for prescaled_timer: tick every presc+1 enabled cycles.
module timer_prescaler
  import prescaled_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en & (cnt == presc);

  // Lowering presc below cnt wraps through 2^PRESC_W before the next tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prescaled_timer.sv
// Prescaled timer peripheral: free-run / periodic / one-shot, match and ovf.
// Optional capture port set under PRESCALED_TIMER_CAPTURE_EN.
module prescaled_timer
  import prescaled_timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   cmp,
`ifdef PRESCALED_TIMER_CAPTURE_EN
  input  logic               cap_trig,
  output logic [WIDTH-1:0]   cap_val,
  output logic               cap_valid,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               match,
  output logic               ovf
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             match_nxt;
  logic             ovf_nxt;
  logic             rearm;
  logic             rearm_nxt;
  logic             clr;
  logic             tick;
  logic             tick_go;
  logic             hit;
  logic             all1;
  logic [WIDTH-1:0] inc;
  mode_e            m;

  assign m    = norm_mode(mode);
  assign hit  = (count == cmp);
  assign all1 = &count;
  assign inc  = count + 1'b1;

  assign tick_go = tick & ~load & ~stop;

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (state == ST_RUN),
    .presc(presc),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      running <= 1'b0;
      match   <= 1'b0;
      ovf     <= 1'b0;
      rearm   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      running <= (state_nxt == ST_RUN);
      match   <= match_nxt;
      ovf     <= ovf_nxt;
      rearm   <= rearm_nxt;
    end
  end

  // rearm lets a one-shot restarted from DONE step past the value it
  // stopped on instead of matching again on the very first tick.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    match_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    rearm_nxt = rearm;
    clr       = 1'b0;
    if (load) begin
      count_nxt = load_val;
      clr       = 1'b1;
      rearm_nxt = 1'b0;
    end
    if (state == ST_RUN && stop) begin
      state_nxt = ST_IDLE;
      clr       = 1'b1;
    end else if (start && !load && state != ST_RUN) begin
      state_nxt = ST_RUN;
      clr       = 1'b1;
      rearm_nxt = (state == ST_DONE);
    end
    if (tick_go) begin
      rearm_nxt = 1'b0;
      unique case (1'b1)
        (m == MODE_PERIODIC): begin
          if (hit) begin
            count_nxt = '0;
            match_nxt = 1'b1;
          end else begin
            count_nxt = inc;
            ovf_nxt   = all1;
          end
        end
        (m == MODE_ONESHOT): begin
          if (hit && !rearm) begin
            match_nxt = 1'b1;
            state_nxt = ST_DONE;
            clr       = 1'b1;
          end else begin
            count_nxt = inc;
            ovf_nxt   = all1;
          end
        end
        default: begin
          count_nxt = inc;
          match_nxt = hit;
          ovf_nxt   = all1;
        end
      endcase
    end
  end

`ifdef PRESCALED_TIMER_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= cap_trig;
      if (cap_trig) cap_val <= count;
    end
  end
`endif

endmodule

// File: tb/tb_prescaled_timer.sv
// Self-checking bench for prescaled_timer with a cycle-level reference model.
module tb_prescaled_timer;

  localparam int W  = 8;
  localparam int PW = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int PMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [1:0]    mode = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  cmp = '0;
  logic [W-1:0]  count;
  logic          running;
  logic          match;
  logic          ovf;
`ifdef PRESCALED_TIMER_CAPTURE_EN
  logic          cap_trig = 1'b0;
  logic [W-1:0]  cap_val;
  logic          cap_valid;
`endif

  int total = 0;
  int bad = 0;

  int m_st;
  int m_cnt;
  int m_psc;
  bit m_rearm;
  bit m_match;
  bit m_ovf;

  always #5 clk = ~clk;

  prescaled_timer #(
    .WIDTH  (W),
    .PRESC_W(PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .presc    (presc),
    .cmp      (cmp),
`ifdef PRESCALED_TIMER_CAPTURE_EN
    .cap_trig (cap_trig),
    .cap_val  (cap_val),
    .cap_valid(cap_valid),
`endif
    .count    (count),
    .running  (running),
    .match    (match),
    .ovf      (ovf)
  );

  function automatic logic [W+2:0] expv();
    logic [W-1:0] c;
    c = m_cnt[W-1:0];
    return {c, (m_st == 1), m_match, m_ovf};
  endfunction

  task automatic mreset();
    m_st = 0; m_cnt = 0; m_psc = 0;
    m_rearm = 0; m_match = 0; m_ovf = 0;
  endtask

  // Advance one clock edge; the model follows the documented rules
  // using the inputs that were stable at that edge.
  task automatic step();
    int md, c_old, st_old;
    bit tk, hit, r, clrp;
    @(posedge clk);
    md = (mode == 2'd3) ? 0 : int'(mode);
    st_old = m_st;
    c_old = m_cnt;
    r = m_rearm;
    tk = (m_st == 1) && (m_psc == int'(presc));
    hit = (c_old == int'(cmp));
    m_match = 0; m_ovf = 0; clrp = 0;
    if (load) begin
      m_cnt = int'(load_val); clrp = 1; m_rearm = 0;
    end
    if (m_st == 1 && stop) begin
      m_st = 0; clrp = 1;
    end else if (start && !load && m_st != 1) begin
      m_rearm = (m_st == 2); m_st = 1; clrp = 1;
    end else if (tk && !load) begin
      m_rearm = 0;
      if (md == 1 && hit) begin
        m_cnt = 0; m_match = 1;
      end else if (md == 2 && hit && !r) begin
        m_match = 1; m_st = 2; clrp = 1;
      end else begin
        m_match = (md == 0) && hit;
        m_ovf = (c_old == MAXV);
        m_cnt = (c_old + 1) % (MAXV + 1);
      end
    end
    if (clrp) m_psc = 0;
    else if (st_old == 1) m_psc = tk ? 0 : (m_psc + 1) % PMOD;
    #1;
  endtask

  task automatic halt_clear(input logic [W-1:0] v);
    stop = 1; load = 1; load_val = v;
    step();
    stop = 0; load = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    mreset();
    #12;
    total++;
    if ({count, running, match, ovf} !== '0)
      $display("FAIL reset: got %h want 0", {count, running, match, ovf});
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_freerun();
    int nm = 0;
    mode = 0; presc = 0; cmp = 5;
    start = 1; step(); start = 0;
    total++;
    if ({count, running} !== {8'd0, 1'b1}) begin
      bad++;
      $display("FAIL fr_start: got %h/%b want 00/1", count, running);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if ({count, running, match, ovf} !== {8'(k), 1'b1, (k == 6), 1'b0}) begin
        bad++;
        $display("FAIL fr_k%0d: got %h %b%b%b want %h 1%b0",
                 k, count, running, match, ovf, 8'(k), (k == 6));
      end
      nm += int'(match);
    end
    total++;
    if (nm !== 1) begin
      bad++;
      $display("FAIL fr_nmatch: got %0d want 1", nm);
    end
  endtask

  task automatic test_periodic();
    halt_clear(8'd0);
    mode = 1; presc = 3; cmp = 2;
    start = 1; step(); start = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      total++;
      if ({count, running, match, ovf} !==
          {8'((k / 4) % 3), 1'b1, (k % 12 == 0), 1'b0}) begin
        bad++;
        $display("FAIL per_k%0d: got %h %b%b%b want %h 1%b0",
                 k, count, running, match, ovf, 8'((k / 4) % 3), (k % 12 == 0));
      end
    end
  endtask

  task automatic test_oneshot();
    int nm = 0;
    int no = 0;
    halt_clear(8'd0);
    mode = 2; presc = 0; cmp = 3;
    start = 1; step(); start = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if ({count, running, match, ovf} !==
          {8'(k < 4 ? k : 3), (k < 4), (k == 4), 1'b0}) begin
        bad++;
        $display("FAIL os_k%0d: got %h %b%b%b", k, count, running, match, ovf);
      end
    end
    start = 1; step(); start = 0;
    for (int k = 1; k <= 260; k++) begin
      step();
      nm += int'(match);
      no += int'(ovf);
      total++;
      if ({count, running, match, ovf} !== expv()) begin
        bad++;
        $display("FAIL os2_k%0d: got %h want %h",
                 k, {count, running, match, ovf}, expv());
      end
    end
    total++;
    if ({count, running, 8'(nm), 8'(no)} !== {8'd3, 1'b0, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL os2_end: cnt %h run %b nm %0d no %0d want 03 0 1 1",
               count, running, nm, no);
    end
  endtask

  task automatic test_overflow();
    halt_clear(8'hFE);
    mode = 0; presc = 0; cmp = 8'h10;
    start = 1; step(); start = 0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) step();
      total++;
      if ({count, ovf} !== {8'((254 + k) % 256), (k == 2)}) begin
        bad++;
        $display("FAIL ovf_k%0d: got %h/%b want %h/%b",
                 k, count, ovf, 8'((254 + k) % 256), (k == 2));
      end
    end
  endtask

  task automatic test_priority();
    load = 1; stop = 1; start = 1; load_val = 8'h5A;
    step();
    load = 0; stop = 0; start = 0;
    total++;
    if ({count, running} !== {8'h5A, 1'b0}) begin
      bad++;
      $display("FAIL prio_run: got %h/%b want 5a/0", count, running);
    end
    load = 1; stop = 1; start = 1; load_val = 8'h33;
    step();
    load = 0; stop = 0; start = 0;
    total++;
    if ({count, running} !== {8'h33, 1'b0}) begin
      bad++;
      $display("FAIL prio_idle: got %h/%b want 33/0", count, running);
    end
  endtask

  task automatic test_async_reset();
    mode = 0; presc = 0; cmp = 8'hF0;
    start = 1; step(); start = 0;
    step(); step();
    #2 rst = 0;
    #1;
    total++;
    if ({count, running, match, ovf} !== '0) begin
      bad++;
      $display("FAIL arst: got %h want 0", {count, running, match, ovf});
    end
    mreset();
    #1 rst = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 79) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 149) == 0) presc = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) cmp = W'($urandom_range(0, 40));
      step();
      total++;
      if ({count, running, match, ovf} !== expv()) begin
        bad++;
        $display("FAIL rnd_%0d: got %h want %h",
                 i, {count, running, match, ovf}, expv());
      end
    end
    start = 0; stop = 0; load = 0;
  endtask

`ifdef PRESCALED_TIMER_CAPTURE_EN
  task automatic test_capture();
    halt_clear(8'd5);
    mode = 0; presc = 0; cmp = 8'd200;
    start = 1; step(); start = 0;
    step(); step();
    cap_trig = 1; step(); cap_trig = 0;
    total++;
    if ({cap_val, cap_valid, count} !== {8'd7, 1'b1, 8'd8}) begin
      bad++;
      $display("FAIL cap: got %h/%b/%h want 07/1/08", cap_val, cap_valid, count);
    end
    step();
    total++;
    if ({cap_val, cap_valid} !== {8'd7, 1'b0}) begin
      bad++;
      $display("FAIL cap_pulse: got %h/%b want 07/0", cap_val, cap_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    if ({count, running} !== '0) bad++;
    test_freerun();
    test_periodic();
    test_oneshot();
    test_overflow();
    test_priority();
    test_async_reset();
    test_random();
`ifdef PRESCALED_TIMER_CAPTURE_EN
    test_capture();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prescaled_timer.md
Name: prescaled_timer

Overview:
- Parametrised successor to the 32-bit free-running counter: configurable width and prescaler, three counting modes, compare-match event and overflow event.
- Sits as the processor's timer peripheral, feeding the interrupt logic via the match/ovf pulses.
- All outputs are registered; software-visible configuration arrives on plain ports from the bus-register block.

Parameters:
- WIDTH, 32, counter and compare width in bits (>= 2).
- PRESC_W, 8, prescaler divisor width in bits (>= 1).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; IDLE/DONE -> RUN.
- stop  input  1  pulse; RUN -> IDLE, count holds.
- load  input  1  pulse; count <= load_val.
- load_val  input  WIDTH  value for load.
- mode  input  2  0 free-run, 1 periodic, 2 one-shot, 3 reserved (treated as free-run).
- presc  input  PRESC_W  tick every presc+1 clk cycles.
- cmp  input  WIDTH  compare value.
- count  output  WIDTH  current counter value.
- running  output  1  high in RUN.
- match  output  1  one-cycle pulse on compare event.
- ovf  output  1  one-cycle pulse on wrap all-ones -> 0.

Behaviour:
- Reset (rst=0, asynchronous): count=0, prescaler=0, state=IDLE, running=0, match=0, ovf=0. Resumes on the first clk edge after rst rises. Reset mid-RUN aborts immediately.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - DONE --start--> RUN.
  - RUN --stop--> IDLE.
  - RUN --one-shot match--> DONE.
- Prescaler:
  - Cleared on start, load and leaving RUN.
  - In RUN it increments each cycle. When prescaler==presc, it asserts an internal tick and returns to 0.
  - presc=0 gives a tick every cycle. The first tick falls presc+1 cycles after the start edge.
- On a tick, count_old is the value before the tick:
  - Free-run: count <= count_old+1, wrapping modulo 2^WIDTH. match=1 if count_old==cmp. ovf=1 if count_old is all-ones.
  - Periodic: if count_old==cmp, then count <= 0 and match=1. Otherwise count <= count_old+1. Wrap past all-ones is allowed (ovf=1) when cmp < count_old. Period = (cmp+1)*(presc+1) cycles.
  - One-shot: if count_old==cmp, count holds, match=1, state <= DONE. Otherwise count <= count_old+1, with wrap/ovf as in periodic.
- match and ovf are registered. They are high for exactly the cycle after the tick edge and are 0 otherwise.
- Command priority in the same cycle: load > stop > start. load does not change state. Simultaneous load and stop applies both (value loaded, state IDLE).
- start while RUN: ignored. stop while IDLE/DONE: ignored.
- mode, presc and cmp are sampled every cycle; changes take effect at the next tick or prescaler compare.
- Lowering presc below the current prescaler value causes a wrap through 2^PRESC_W before the next tick. This is documented, not an error.
- cmp=0 in periodic mode: count stays 0 and match pulses every tick.
- In DONE, count holds at cmp and running=0.

Optional Feature:
- Macro: PRESCALED_TIMER_CAPTURE_EN.
- Defined: adds three ports.
  - cap_trig  input  1: when high in a cycle, cap_val <= count on that edge.
  - cap_val  output  WIDTH: captured value, reset value 0.
  - cap_valid  output  1: pulses for one cycle after each capture.
  - Capture works in every state. If cap_trig coincides with a tick, the pre-tick count is captured.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package prescaled_timer_pkg holds:
  - mode encodings MODE_FREE=0, MODE_PERIODIC=1, MODE_ONESHOT=2.
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module timer_prescaler: clk, rst, clr, en, presc -> tick. Instantiated once.

Test Plan:
- Reset then free-run: WIDTH=32, presc=0, cmp=5, start. count reads 1,2,3… each cycle; match pulses once, in the cycle after count goes 5->6.
- Prescaler and periodic mode: presc=3, cmp=2, mode=1. count sequence 0,1,2,0 with each value lasting 4 cycles; match pulses every 12 cycles.
- One-shot: cmp=3, presc=0, mode=2. count stops at 3, DONE reached, running=0, single match pulse. A second start re-runs from 3: wraps through all-ones (ovf pulse) and matches again at 3.
- Overflow: WIDTH=8, load_val=8'hFE, free-run. count goes FE, FF, 00; ovf pulses exactly once.
- Priority and async reset: load+stop+start in the same cycle gives count=load_val and state IDLE. rst low mid-RUN clears count to 0 without a clk edge.
- With PRESCALED_TIMER_CAPTURE_EN: cap_trig asserted while count=7 on a tick edge gives cap_val=7 and cap_valid high for one cycle.
